seq_detector_param: RTL and testbench

// - Parametrised serial bit-sequence detector; next generation of the fixed Mealy overlapping FSM detector.
// - Generalises to any pattern length and value, with runtime pattern reload.
// - Selectable overlapping/non-overlapping matching and Mealy/Moore output timing.
// - Saturating match counter for lab/board observation.
// - Sits between a serial bit source (switch/debounced input or shift stream) and LEDs or a downstream counter.

---
 rtl/seq_detector_param_pkg.sv | 9 +
 rtl/seq_detector_param_if.sv | 26 ++
 rtl/sat_counter.sv | 25 ++
 rtl/seq_detector_param.sv | 79 +++++++
 tb/tb_seq_detector_param.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/seq_detector_param_pkg.sv
// Shared constants for the serial sequence detector family.
package seq_detector_param_pkg;

  localparam bit MODE_MEALY = 1'b0;
  localparam bit MODE_MOORE = 1'b1;
  localparam bit OVL_OFF    = 1'b0;
  localparam bit OVL_ON     = 1'b1;

endpackage

// File: rtl/seq_detector_param_if.sv
// Serial-bit / pattern-control / match-report bundle for seq_detector_param.
interface seq_detector_param_if #(
  parameter int unsigned PAT_LEN = 4,
  parameter int unsigned CNT_W   = 8
);

  logic               en;
  logic               x;
  logic               pat_load;
  logic [PAT_LEN-1:0] pat_in;
  logic               cnt_clear;
  logic               y;
  logic [CNT_W-1:0]   match_cnt;
  logic               cnt_sat;

  modport master (
    output en, x, pat_load, pat_in, cnt_clear,
    input  y, match_cnt, cnt_sat
  );

  modport slave (
    input  en, x, pat_load, pat_in, cnt_clear,
    output y, match_cnt, cnt_sat
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q,
  output logic         sat
);

  assign sat = &q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && !sat) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector: shift-history compare against a reloadable
// pattern, overlap/non-overlap matching, Mealy or Moore match pulse, saturating match count.
module seq_detector_param
  import seq_detector_param_pkg::*;
#(
  parameter int unsigned        PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1010,
  parameter bit                 OVERLAP = OVL_ON,
  parameter bit                 MOORE   = MODE_MEALY,
  parameter int unsigned        CNT_W   = 8
) (
  input  logic               clock,
  input  logic               reset,
  seq_detector_param_if.slave bus
);

  localparam int unsigned FILL_W   = $clog2(PAT_LEN);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_LEN - 1);

  logic [PAT_LEN-1:0] hist;
  logic [PAT_LEN-1:0] hist_n;
  logic [PAT_LEN-1:0] pat;
  logic [FILL_W-1:0]  fill;
  logic               hit;

  assign hist_n = {hist[PAT_LEN-2:0], bus.x};

  // A match needs a full window of fresh bits; reset and a pattern reload both suppress it.
  assign hit = bus.en & reset & ~bus.pat_load & (hist_n == pat) & (fill == FILL_MAX);

  always_ff @(posedge clock) begin
    if (!reset) begin
      hist <= '0;
      fill <= '0;
      pat  <= PATTERN;
    end else if (bus.pat_load) begin
      pat  <= bus.pat_in;
      hist <= '0;
      fill <= '0;
    end else if (bus.en) begin
      hist <= hist_n;
      if (hit && (OVERLAP == OVL_OFF)) begin
        fill <= '0;
      end else if (fill != FILL_MAX) begin
        fill <= fill + FILL_W'(1);
      end
    end
  end

  generate
    if (MOORE == MODE_MOORE) begin : g_moore
      logic y_reg;

      always_ff @(posedge clock) begin
        if (!reset) begin
          y_reg <= 1'b0;
        end else begin
          y_reg <= hit;
        end
      end

      assign bus.y = y_reg;
    end else begin : g_mealy
      assign bus.y = hit;
    end
  endgenerate

  sat_counter #(
    .W (CNT_W)
  ) u_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (hit),
    .clr   (bus.cnt_clear),
    .q     (bus.match_cnt),
    .sat   (bus.cnt_sat)
  );

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboarded directed bench over four detector configurations.
module tb_seq_detector_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       en_v  [4];
  logic       x_v   [4];
  logic       pl_v  [4];
  logic [3:0] pi_v  [4];
  logic       clr_v [4];
  logic       rst_v [4];
  logic       y_w   [4];
  logic [7:0] cnt_w [4];
  logic       sat_w [4];

  seq_detector_param_if #(.PAT_LEN(4), .CNT_W(8)) b0 ();
  seq_detector_param_if #(.PAT_LEN(4), .CNT_W(8)) b1 ();
  seq_detector_param_if #(.PAT_LEN(4), .CNT_W(8)) b2 ();
  seq_detector_param_if #(.PAT_LEN(4), .CNT_W(2)) b3 ();

  // d0: Mealy overlap, d1: Mealy non-overlap, d2: Moore overlap, d3: Mealy overlap 2-bit counter
  seq_detector_param #(.PAT_LEN(4), .PATTERN(4'b1010), .OVERLAP(1'b1), .MOORE(1'b0), .CNT_W(8))
    d0 (.clock(clk), .reset(rst_v[0]), .bus(b0));
  seq_detector_param #(.PAT_LEN(4), .PATTERN(4'b1010), .OVERLAP(1'b0), .MOORE(1'b0), .CNT_W(8))
    d1 (.clock(clk), .reset(rst_v[1]), .bus(b1));
  seq_detector_param #(.PAT_LEN(4), .PATTERN(4'b1010), .OVERLAP(1'b1), .MOORE(1'b1), .CNT_W(8))
    d2 (.clock(clk), .reset(rst_v[2]), .bus(b2));
  seq_detector_param #(.PAT_LEN(4), .PATTERN(4'b1010), .OVERLAP(1'b1), .MOORE(1'b0), .CNT_W(2))
    d3 (.clock(clk), .reset(rst_v[3]), .bus(b3));

  assign b0.en = en_v[0];  assign b0.x = x_v[0];  assign b0.pat_load = pl_v[0];
  assign b0.pat_in = pi_v[0];  assign b0.cnt_clear = clr_v[0];
  assign b1.en = en_v[1];  assign b1.x = x_v[1];  assign b1.pat_load = pl_v[1];
  assign b1.pat_in = pi_v[1];  assign b1.cnt_clear = clr_v[1];
  assign b2.en = en_v[2];  assign b2.x = x_v[2];  assign b2.pat_load = pl_v[2];
  assign b2.pat_in = pi_v[2];  assign b2.cnt_clear = clr_v[2];
  assign b3.en = en_v[3];  assign b3.x = x_v[3];  assign b3.pat_load = pl_v[3];
  assign b3.pat_in = pi_v[3];  assign b3.cnt_clear = clr_v[3];

  assign y_w[0] = b0.y;  assign cnt_w[0] = b0.match_cnt;          assign sat_w[0] = b0.cnt_sat;
  assign y_w[1] = b1.y;  assign cnt_w[1] = b1.match_cnt;          assign sat_w[1] = b1.cnt_sat;
  assign y_w[2] = b2.y;  assign cnt_w[2] = b2.match_cnt;          assign sat_w[2] = b2.cnt_sat;
  assign y_w[3] = b3.y;  assign cnt_w[3] = {6'b0, b3.match_cnt};  assign sat_w[3] = b3.cnt_sat;

  typedef struct {
    int         dut;
    logic       y;
    logic [7:0] cnt;
    logic       sat;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  // Monitor: one expectation per driven cycle, checked mid-cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_vec++;
      if (y_w[e.dut] !== e.y) begin
        n_miss++;
        $display("FAIL %s d%0d y: got %b want %b", e.tag, e.dut, y_w[e.dut], e.y);
      end
      if (cnt_w[e.dut] !== e.cnt) begin
        n_miss++;
        $display("FAIL %s d%0d match_cnt: got %0d want %0d", e.tag, e.dut, cnt_w[e.dut], e.cnt);
      end
      if (sat_w[e.dut] !== e.sat) begin
        n_miss++;
        $display("FAIL %s d%0d cnt_sat: got %b want %b", e.tag, e.dut, sat_w[e.dut], e.sat);
      end
    end
  end

  task automatic step(input int d, input logic e, input logic xx, input logic pl,
                      input logic [3:0] pi, input logic clr, input logic r,
                      input logic ey, input int ecnt, input logic esat, input string tag);
    exp_t ex;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      en_v[i] = 1'b0; x_v[i] = 1'b0; pl_v[i] = 1'b0;
      pi_v[i] = 4'b0; clr_v[i] = 1'b0; rst_v[i] = 1'b1;
    end
    en_v[d] = e; x_v[d] = xx; pl_v[d] = pl; pi_v[d] = pi; clr_v[d] = clr; rst_v[d] = r;
    ex.dut = d; ex.y = ey; ex.cnt = 8'(ecnt); ex.sat = esat; ex.tag = tag;
    sb.push_back(ex);
  endtask

  task automatic bit_in(input int d, input logic xx, input logic ey, input int ecnt,
                        input logic esat, input string tag);
    step(d, 1'b1, xx, 1'b0, 4'b0, 1'b0, 1'b1, ey, ecnt, esat, tag);
  endtask

  task automatic idle(input int d, input logic ey, input int ecnt, input logic esat,
                      input string tag);
    step(d, 1'b0, 1'b0, 1'b0, 4'b0, 1'b0, 1'b1, ey, ecnt, esat, tag);
  endtask

  task automatic rst_chk(input int d, input logic xx, input int ecnt, input string tag);
    step(d, 1'b1, xx, 1'b0, 4'b0, 1'b0, 1'b0, 1'b0, ecnt, 1'b0, tag);
  endtask

  logic [9:0] alt  = 10'b1010101010;
  logic [3:0] ld_b = 4'b1100;

  initial begin
    for (int i = 0; i < 4; i++) begin
      en_v[i] = 1'b0; x_v[i] = 1'b0; pl_v[i] = 1'b0;
      pi_v[i] = 4'b0; clr_v[i] = 1'b0; rst_v[i] = 1'b0;
    end
    repeat (2) @(posedge clk);

    for (int d = 0; d < 4; d++) rst_chk(d, 1'b1, 0, "reset");

    // Mealy overlapping: hits on bits 4 and 6
    for (int i = 0; i < 6; i++)
      bit_in(0, alt[9-i], (i == 3 || i == 5), (i < 4) ? 0 : 1, 1'b0, "mealy_ovl");
    idle(0, 1'b0, 2, 1'b0, "mealy_ovl_cnt");

    // Reset mid-sequence discards the partial 1,0,1
    rst_chk(0, 1'b0, 2, "mid_rst_a");
    for (int i = 0; i < 3; i++) bit_in(0, alt[9-i], 1'b0, 0, 1'b0, "pre_rst");
    rst_chk(0, 1'b0, 0, "mid_rst_b");
    bit_in(0, 1'b0, 1'b0, 0, 1'b0, "post_rst0");
    for (int i = 0; i < 4; i++) bit_in(0, alt[9-i], (i == 3), 0, 1'b0, "post_rst");
    idle(0, 1'b0, 1, 1'b0, "post_rst_cnt");

    // Runtime load of 1100
    step(0, 1'b1, 1'b1, 1'b1, 4'b1100, 1'b0, 1'b1, 1'b0, 1, 1'b0, "load");
    for (int i = 0; i < 4; i++) bit_in(0, ld_b[3-i], (i == 3), 1, 1'b0, "new_pat");
    for (int i = 0; i < 4; i++) bit_in(0, alt[9-i], 1'b0, 2, 1'b0, "old_pat_miss");
    for (int i = 0; i < 3; i++) bit_in(0, ld_b[3-i], 1'b0, 2, 1'b0, "pre_load2");
    // Completing bit arrives with pat_load: discarded, no hit
    step(0, 1'b1, 1'b0, 1'b1, 4'b1100, 1'b0, 1'b1, 1'b0, 2, 1'b0, "load_blocks_hit");
    bit_in(0, 1'b0, 1'b0, 2, 1'b0, "load_clears_hist");
    idle(0, 1'b0, 2, 1'b0, "load_cnt");

    // Mealy non-overlapping: hits on bits 4 and 8 only
    for (int i = 0; i < 8; i++)
      bit_in(1, alt[9-i], (i == 3 || i == 7), (i < 4) ? 0 : 1, 1'b0, "mealy_novl");
    idle(1, 1'b0, 2, 1'b0, "mealy_novl_cnt");

    // en gaps hold state
    bit_in(1, 1'b1, 1'b0, 2, 1'b0, "gap_a");
    bit_in(1, 1'b0, 1'b0, 2, 1'b0, "gap_b");
    for (int i = 0; i < 3; i++)
      step(1, 1'b0, alt[9-i], 1'b0, 4'b0, 1'b0, 1'b1, 1'b0, 2, 1'b0, "gap_en0");
    bit_in(1, 1'b1, 1'b0, 2, 1'b0, "gap_c");
    bit_in(1, 1'b0, 1'b1, 2, 1'b0, "gap_d");
    idle(1, 1'b0, 3, 1'b0, "gap_cnt");

    // Moore: pulse one cycle after the 4th bit, one cycle wide
    for (int i = 0; i < 4; i++) bit_in(2, alt[9-i], 1'b0, 0, 1'b0, "moore");
    idle(2, 1'b1, 1, 1'b0, "moore_pulse");
    idle(2, 1'b0, 1, 1'b0, "moore_width");
    bit_in(2, 1'b1, 1'b0, 1, 1'b0, "moore_ovl_a");
    bit_in(2, 1'b0, 1'b0, 1, 1'b0, "moore_ovl_b");
    // Pending Moore pulse still shows during a pattern load
    step(2, 1'b1, 1'b1, 1'b1, 4'b1010, 1'b0, 1'b1, 1'b1, 2, 1'b0, "moore_pend_load");
    idle(2, 1'b0, 2, 1'b0, "moore_after_load");

    // 2-bit counter saturation, then clear beating a simultaneous hit
    for (int i = 0; i < 10; i++)
      bit_in(3, alt[9-i], (i == 3 || i == 5 || i == 7 || i == 9),
             (i < 4) ? 0 : (i < 6) ? 1 : (i < 8) ? 2 : 3, (i >= 8), "sat");
    idle(3, 1'b0, 3, 1'b1, "sat_hold");
    bit_in(3, 1'b1, 1'b0, 3, 1'b1, "clr_pre");
    step(3, 1'b1, 1'b0, 1'b0, 4'b0, 1'b1, 1'b1, 1'b1, 3, 1'b1, "clr_with_hit");
    idle(3, 1'b0, 0, 1'b0, "clr_result");

    @(posedge clk);
    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_miss++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
